bp_compete: RTL and testbench

- Tournament selector downstream of the global-history and local-history direction predictors.
- In Fetch, chooses between the two direction bits using a per-PC 2-bit choice counter table (CPHT) and produces the final predicted direction.
- Carries both component predictions and the choice down the F→D→E→M pipeline, alongside the existing predictor checkpoints.
- Trains the CPHT in Memory when the branch resolves, and flags mispredicts.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/sat_counter2.sv | 22 ++
 rtl/bp_compete.sv | 126 ++++++++++++
 tb/tb_bp_compete.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the tournament branch-direction selector.
package bp_pkg;

    // 2-bit choice counter: upper bit selects the local predictor.
    typedef enum logic [1:0] {
        STRONG_GLOBAL = 2'b00,
        WEAK_GLOBAL   = 2'b01,
        WEAK_LOCAL    = 2'b10,
        STRONG_LOCAL  = 2'b11
    } choice_t;

    // Prediction state carried alongside each instruction from F to M.
    typedef struct packed {
        logic pred_global;
        logic pred_local;
        logic choice;
        logic pcsrcP;
    } bp_payload_t;

    localparam choice_t     CPHT_RESET    = WEAK_GLOBAL;
    localparam bp_payload_t PAYLOAD_CLEAR = '0;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating choice counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] nxt
);

    // Step toward local on inc, toward global on dec, clamp at both ends.
    always_comb begin
        // NOTE: default assignment first so no path leaves nxt unassigned (no latch).
        nxt = cur;
        if (inc && !dec && cur != STRONG_LOCAL) begin
            nxt = cur + 2'd1;
        end else if (dec && !inc && cur != STRONG_GLOBAL) begin
            nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/bp_compete.sv
// Tournament selector: picks global vs local direction per PC in Fetch,
// carries the prediction to Memory, and trains the choice table there.
module bp_compete
    import bp_pkg::*;
#(
    parameter int CPHT_DEPTH = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pcF,
    input  logic [31:0]          pcM,
    input  logic                 pred_globalF,
    input  logic                 pred_localF,
    input  logic                 stallD,
    input  logic                 flushD,
    input  logic                 flushE,
    input  logic                 flushM,
    input  logic                 branchM,
    input  logic                 pcsrcM,
    output logic                 pcsrcPF,
    output logic                 pcsrcPM,
    output logic                 mispredM,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int                   CPHT_ENTRIES = 1 << CPHT_DEPTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

    choice_t              cpht_q [CPHT_ENTRIES];
    choice_t              cpht_d [CPHT_ENTRIES];
    bp_payload_t          fd_q, fd_d, de_q, de_d, em_q, em_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [CPHT_DEPTH-1:0] idx_f, idx_m;
    choice_t               entry_f;
    logic                  choice_f;
    logic                  g_ok, l_ok;
    logic [1:0]            entry_m_nxt;
    logic                  unused_bits;

    assign idx_f    = pcF[CPHT_DEPTH+1:2];
    assign idx_m    = pcM[CPHT_DEPTH+1:2];
    assign entry_f  = cpht_q[idx_f];
    assign choice_f = entry_f[1];
    // Fetch reads the registered table: an M-stage write this cycle is not visible yet.
    assign pcsrcPF  = choice_f ? pred_localF : pred_globalF;

    assign pcsrcPM     = em_q.pcsrcP;
    assign mispredM    = branchM & (em_q.pcsrcP ^ pcsrcM);
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    assign g_ok = (em_q.pred_global == pcsrcM);
    assign l_ok = (em_q.pred_local  == pcsrcM);

    assign unused_bits = ^{pcF[31:CPHT_DEPTH+2], pcF[1:0],
                           pcM[31:CPHT_DEPTH+2], pcM[1:0], em_q.choice};

    sat_counter2 u_sat (
        .cur (cpht_q[idx_m]),
        .inc (l_ok & ~g_ok),
        .dec (g_ok & ~l_ok),
        .nxt (entry_m_nxt)
    );

    // Next-state for the table, the three stage registers and the counters.
    always_comb begin
        cpht_d = cpht_q;
        if (branchM) begin
            cpht_d[idx_m] = choice_t'(entry_m_nxt);
        end

        // flushD wins over stallD so a squashed slot never survives a stall.
        if (flushD) begin
            fd_d = PAYLOAD_CLEAR;
        end else if (stallD) begin
            fd_d = fd_q;
        end else begin
            fd_d.pred_global = pred_globalF;
            fd_d.pred_local  = pred_localF;
            fd_d.choice      = choice_f;
            fd_d.pcsrcP      = pcsrcPF;
        end

        de_d = flushE ? PAYLOAD_CLEAR : fd_q;
        em_d = flushM ? PAYLOAD_CLEAR : de_q;

        branch_cnt_d = branch_cnt_q;
        if (branchM && branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        mispred_cnt_d = mispred_cnt_q;
        if (mispredM && mispred_cnt_q != CNT_MAX) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end
    end

    // State update with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the table is a reset flop array, not a RAM: every entry must
            // restart at weak-global so reset discards all learned choices.
            for (int i = 0; i < CPHT_ENTRIES; i++) begin
                cpht_q[i] <= CPHT_RESET;
            end
            fd_q          <= PAYLOAD_CLEAR;
            de_q          <= PAYLOAD_CLEAR;
            em_q          <= PAYLOAD_CLEAR;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            cpht_q        <= cpht_d;
            fd_q          <= fd_d;
            de_q          <= de_d;
            em_q          <= em_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_compete.sv
// Scoreboard bench for bp_compete: expectations are queued with the cycle
// they become due and compared on the falling edge of that cycle.
module tb_bp_compete;

    localparam logic [31:0] PC_A = 32'h0040_0000;  // CPHT index 0
    localparam logic [31:0] PC_B = 32'h0040_0010;  // CPHT index 4

    logic        clk, rst;
    logic [31:0] pcF, pcM;
    logic        pred_globalF, pred_localF;
    logic        stallD, flushD, flushE, flushM;
    logic        branchM, pcsrcM;
    logic        pcsrcPF, pcsrcPM, mispredM;
    logic [31:0] branch_cnt, mispred_cnt;

    bp_compete #(.CPHT_DEPTH(6), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .pcM(pcM),
        .pred_globalF(pred_globalF), .pred_localF(pred_localF),
        .stallD(stallD), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .branchM(branchM), .pcsrcM(pcsrcM),
        .pcsrcPF(pcsrcPF), .pcsrcPM(pcsrcPM), .mispredM(mispredM),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {S_PF, S_PM, S_MIS, S_BC, S_MC} sel_e;
    typedef struct {
        int          due;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push_exp(input int off, input sel_e sel, input logic [31:0] val);
        exp_t e;
        e.due = cyc + off;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] sample(input sel_e s);
        case (s)
            S_PF:    return {31'd0, pcsrcPF};
            S_PM:    return {31'd0, pcsrcPM};
            S_MIS:   return {31'd0, mispredM};
            S_BC:    return branch_cnt;
            default: return mispred_cnt;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check($sformatf("%s@%0d", sb[i].sel.name(), sb[i].due),
                      sample(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    // Advance one cycle and return inputs to idle defaults.
    task automatic next();
        @(posedge clk);
        #1;
        rst = 1'b0; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0; flushM = 1'b0;
        branchM = 1'b0; pcsrcM = 1'b0; pcM = 32'h0;
        pcF = PC_B; pred_globalF = 1'b0; pred_localF = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic g, input logic l, input logic exp_pf);
        pcF = pc; pred_globalF = g; pred_localF = l;
        push_exp(0, S_PF, {31'd0, exp_pf});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0; flushM = 1'b0;
        branchM = 1'b0; pcsrcM = 1'b0; pcM = 32'h0;
        pcF = PC_B; pred_globalF = 1'b0; pred_localF = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset state; entry 01 selects global.
        fetch(PC_A, 1, 0, 1);
        push_exp(0, S_PM, 0); push_exp(0, S_MIS, 0);
        push_exp(0, S_BC, 0); push_exp(0, S_MC, 0);
        next(); fetch(PC_A, 1, 0, 1);
        next(); fetch(PC_A, 1, 0, 1);

        // Three local-right/global-wrong resolutions: 01 -> 10 -> 11 -> 11.
        // The first fetch shares the cycle with the first update and sees 01.
        for (int k = 0; k < 3; k++) begin
            next();
            fetch(PC_A, 1, 0, (k == 0));
            branchM = 1'b1; pcM = PC_A; pcsrcM = 1'b0;
            push_exp(0, S_PM, 1); push_exp(0, S_MIS, 1);
            push_exp(0, S_BC, k); push_exp(0, S_MC, k);
        end

        // Saturated local entry; predicted-taken in M but no branch.
        next(); fetch(PC_A, 1, 0, 0);
        push_exp(0, S_PM, 1); push_exp(0, S_MIS, 0);
        push_exp(0, S_BC, 3); push_exp(0, S_MC, 3);
        push_exp(1, S_BC, 3); push_exp(1, S_MC, 3);
        next(); fetch(PC_B, 0, 0, 0);
        next(); fetch(PC_B, 0, 0, 0);

        // stallD+flushD together: the taken fetch never reaches M.
        next(); fetch(PC_A, 0, 1, 1); push_exp(3, S_PM, 1);
        next(); fetch(PC_A, 0, 1, 1); stallD = 1'b1; flushD = 1'b1; push_exp(3, S_PM, 0);
        next(); fetch(PC_A, 0, 1, 1);
        // flushE squashes the taken payload sitting in D.
        next(); fetch(PC_B, 0, 0, 0); flushE = 1'b1; push_exp(2, S_PM, 0);
        next(); fetch(PC_B, 0, 0, 0);
        // Resolve against the cleared slot: both components right, entry unchanged.
        next(); fetch(PC_B, 0, 0, 0);
        branchM = 1'b1; pcM = PC_A; pcsrcM = 1'b0;
        push_exp(0, S_MIS, 0); push_exp(1, S_BC, 4); push_exp(1, S_MC, 3);
        next(); fetch(PC_A, 1, 0, 0); push_exp(3, S_PM, 0);
        next(); fetch(PC_A, 0, 1, 1); push_exp(3, S_PM, 1);

        // Saturating mispredict counter.
        next(); fetch(PC_A, 0, 1, 1);
        force dut.mispred_cnt_q = '1;
        next();
        release dut.mispred_cnt_q;
        fetch(PC_A, 0, 1, 1);
        branchM = 1'b1; pcM = PC_A; pcsrcM = 1'b1;
        push_exp(0, S_MIS, 1); push_exp(0, S_MC, 32'hFFFF_FFFF);
        push_exp(1, S_MC, 32'hFFFF_FFFF); push_exp(1, S_BC, 5);

        // Mid-stream reset with a branch also presented: reset wins.
        next(); fetch(PC_A, 0, 1, 1);
        rst = 1'b1; branchM = 1'b1; pcM = PC_A; pcsrcM = 1'b1;
        push_exp(0, S_PM, 1);
        next(); fetch(PC_A, 1, 0, 1);
        push_exp(0, S_PM, 0); push_exp(0, S_MIS, 0);
        push_exp(0, S_BC, 0); push_exp(0, S_MC, 0);
        push_exp(1, S_PM, 0); push_exp(2, S_PM, 0);
        next(); fetch(PC_A, 0, 1, 0);

        repeat (4) next();
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
